cnn_layer_accel_axi_rd_resp_router: RTL and testbench
=====================================================

// Module: cnn_layer_accel_axi_rd_resp_router
// PURPOSE
//  Read-response stage directly downstream of the AXI read master bridge.
//  Accepts the AXI R channel (rid/rdata/rresp/rlast) and steers each beat to
//  the client that issued the burst, using an ID->client table written when
//  the bridge's AR handshake completes.
//  Buffers beats per client in small FIFOs. Emits per-client
//  cX_init_read_data/_vld/_cmpl with rdy backpressure.
// PARAMETERS
//  C_NUM_CLIENTS   8    number of read clients (power of 2, 2..16)
//  C_NUM_IDS       16   AXI ID space; table depth (rid is 4 bits)
//  C_DATA_WTH      64   AXI/client data width
//  C_FIFO_DEPTH    8    beats buffered per client (power of 2, >=2)
// PORTS
//  clk                 in   1                  clock
//  rst                 in   1                  reset; asynchronous, active-low
//  tag_reg_vld         in   1                  AR handshake accepted this cycle
//  tag_reg_id          in   4                  arid of accepted burst
//  tag_reg_client      in   clog2(C_NUM_CLIENTS)  granted client index
//  axi_rid             in   4                  read response ID
//  axi_rdata           in   C_DATA_WTH         read data
//  axi_rresp           in   2                  read response code
//  axi_rlast           in   1                  last beat of burst
//  axi_rvalid          in   1                  read beat valid
//  axi_rready          out  1                  read beat accepted
//  cX_init_read_data   out  C_NUM_CLIENTS*C_DATA_WTH  per-client head data
//  cX_init_read_data_vld out C_NUM_CLIENTS     per-client head valid
//  cX_init_read_data_rdy in  C_NUM_CLIENTS     per-client pop
//  cX_init_read_cmpl   out  C_NUM_CLIENTS      1-cycle pulse: last beat popped
//  resp_err            out  C_NUM_CLIENTS      sticky: rresp!=0 seen for client
//  tag_err             out  1                  sticky: unmapped rid or tag reuse
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset: all outputs 0; FIFOs empty; table entries invalid; sticky flags clear.
//  Reset mid-burst discards buffered data; no cmpl is issued for it.
//  Table: tbl_vld[id], tbl_cli[id].
//  - tag_reg_vld sets tbl_vld[tag_reg_id] and writes tbl_cli at the next edge.
//  - Registering an already-valid id: overwrite it and set tag_err.
//  - Accepted beat with rlast clears tbl_vld[rid].
//  - Same-cycle register and release of the same id: register wins, entry stays valid.
//  Routing: cli = tbl_cli[axi_rid].
//  - axi_rready = tbl_vld[rid] ? (cnt[cli] != C_FIFO_DEPTH) : 1.
//  - axi_rready is combinational on rid; it must not depend on rdy in the same cycle.
//  - Unmapped rid: beat is drained (rready=1), dropped, and tag_err is set.
//  Push: rvalid&&rready&&mapped writes {rlast,rdata} to FIFO[cli].
//  - Any rresp!=0 on an accepted beat sets resp_err[cli].
//  FIFO: registered storage, show-ahead read.
//  - Beat accepted on edge N gives vld=1 with that data from edge N (cycle N+1).
//  - Pop when vld&&rdy; cnt is clog2(C_FIFO_DEPTH+1) bits.
//  - Pointers are clog2(C_FIFO_DEPTH) bits and wrap naturally.
//  - Push and pop in the same cycle leave cnt unchanged.
//  - Full: push is blocked by rready; a pop in the same cycle does not re-open rready that cycle.
//  - Empty: vld=0; data holds its last value (don't-care).
//  cmpl: registered pulse one cycle after popping an entry whose last flag is set.
//  Only one beat is accepted per cycle; different clients drain independently.
// CONFIGURATION
//  CNN_AXI_RD_RESP_BEAT_CNT_EN defined: adds output
//    rd_beat_cnt [C_NUM_CLIENTS*16] with a per-client 16-bit counter of popped beats.
//    Counters saturate at 16'hFFFF and clear on reset or on that client's cmpl pulse.
//  Undefined: the port and the counters are absent; all other behaviour is identical.
// TESTING
//  1. Reg id3->client2; 4-beat burst 0xA0..A3 on rid3, rdy2=1 ->
//     vld2 beats A0..A3 in order; cmpl2 pulses once, one cycle after A3 pops;
//     tbl_vld[3]=0.
//  2. rdy5=0, Reg id1->client5, 12-beat burst on rid1 -> rready drops after 8 beats.
//     Raise rdy5 -> remaining 4 beats accepted; 12 beats delivered, no loss.
//  3. Interleave id1->c0 and id2->c1 beat by beat, rdy0=rdy1=1 -> each client
//     gets only its own data in order; each gets exactly one cmpl.
//  4. Beat on unregistered rid7 -> rready=1, no client vld, tag_err=1 (sticky).
//  5. Burst with rresp=2 on beat 1 -> resp_err of mapped client=1; data delivered.
//  6. Assert rst mid-burst with 3 beats buffered -> all vld=0, cnt=0, no cmpl.
//     New burst after release routes correctly.

Source files
------------

// File: rtl/cnn_layer_accel_axi_rd_resp_router.sv
// AXI read-response router: steers R beats to per-client show-ahead FIFOs via an ID->client table.
// Optional per-client popped-beat counters are enabled by defining CNN_AXI_RD_RESP_BEAT_CNT_EN.
module cnn_layer_accel_axi_rd_resp_router #(
  parameter int C_NUM_CLIENTS = 8,
  parameter int C_NUM_IDS     = 16,
  parameter int C_DATA_WTH    = 64,
  parameter int C_FIFO_DEPTH  = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 tag_reg_vld,
  input  logic [3:0]                           tag_reg_id,
  input  logic [$clog2(C_NUM_CLIENTS)-1:0]     tag_reg_client,
  input  logic [3:0]                           axi_rid,
  input  logic [C_DATA_WTH-1:0]                axi_rdata,
  input  logic [1:0]                           axi_rresp,
  input  logic                                 axi_rlast,
  input  logic                                 axi_rvalid,
  output logic                                 axi_rready,
  output logic [C_NUM_CLIENTS*C_DATA_WTH-1:0]  cX_init_read_data,
  output logic [C_NUM_CLIENTS-1:0]             cX_init_read_data_vld,
  input  logic [C_NUM_CLIENTS-1:0]             cX_init_read_data_rdy,
  output logic [C_NUM_CLIENTS-1:0]             cX_init_read_cmpl,
  output logic [C_NUM_CLIENTS-1:0]             resp_err,
  output logic                                 tag_err
`ifdef CNN_AXI_RD_RESP_BEAT_CNT_EN
  ,
  output logic [C_NUM_CLIENTS*16-1:0]          rd_beat_cnt
`endif
);

  localparam int CW = $clog2(C_NUM_CLIENTS);
  localparam int PW = $clog2(C_FIFO_DEPTH);
  localparam int NW = $clog2(C_FIFO_DEPTH + 1);

  logic          tbl_vld [C_NUM_IDS];
  logic [CW-1:0] tbl_cli [C_NUM_IDS];

  logic [C_NUM_CLIENTS-1:0][NW-1:0] cnt_all;
  logic          mapped;
  logic [CW-1:0] cli;
  logic          acc;
  logic          push;

  assign mapped = tbl_vld[axi_rid];
  assign cli    = tbl_cli[axi_rid];
  // Unmapped beats are always drained so a stray ID can never stall the R channel.
  assign axi_rready = mapped ? (cnt_all[cli] != NW'(C_FIFO_DEPTH)) : 1'b1;
  assign acc  = axi_rvalid && axi_rready;
  assign push = acc && mapped;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < C_NUM_IDS; i++) begin
        tbl_vld[i] <= 1'b0;
        tbl_cli[i] <= '0;
      end
      resp_err <= '0;
      tag_err  <= 1'b0;
    end else begin
      if (push && axi_rlast)
        tbl_vld[axi_rid] <= 1'b0;
      // Registration comes after release so a same-cycle register of the same id wins.
      if (tag_reg_vld) begin
        tbl_vld[tag_reg_id] <= 1'b1;
        tbl_cli[tag_reg_id] <= tag_reg_client;
      end
      if (push && (axi_rresp != 2'b00))
        resp_err[cli] <= 1'b1;
      if ((acc && !mapped) || (tag_reg_vld && tbl_vld[tag_reg_id]))
        tag_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < C_NUM_CLIENTS; g++) begin : g_cli
    logic [C_DATA_WTH:0] mem [C_FIFO_DEPTH];
    logic [C_DATA_WTH:0] head;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [NW-1:0]       cnt;
    logic                cmpl_q;
    logic                push_c;
    logic                pop_c;

    assign push_c = push && (cli == CW'(g));
    assign pop_c  = (cnt != '0) && cX_init_read_data_rdy[g];
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < C_FIFO_DEPTH; i++)
          mem[i] <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        cmpl_q <= 1'b0;
      end else begin
        if (push_c) begin
          mem[wr_ptr] <= {axi_rlast, axi_rdata};
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop_c)
          rd_ptr <= rd_ptr + 1'b1;
        if (push_c && !pop_c)
          cnt <= cnt + 1'b1;
        else if (!push_c && pop_c)
          cnt <= cnt - 1'b1;
        cmpl_q <= pop_c && head[C_DATA_WTH];
      end
    end

    assign cnt_all[g]                                     = cnt;
    assign cX_init_read_data[g*C_DATA_WTH +: C_DATA_WTH]  = head[C_DATA_WTH-1:0];
    assign cX_init_read_data_vld[g]                       = (cnt != '0);
    assign cX_init_read_cmpl[g]                           = cmpl_q;

`ifdef CNN_AXI_RD_RESP_BEAT_CNT_EN
    logic [15:0] beat_cnt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        beat_cnt <= '0;
      else if (cmpl_q)
        beat_cnt <= '0;
      else if (pop_c && (beat_cnt != 16'hFFFF))
        beat_cnt <= beat_cnt + 16'd1;
    end

    assign rd_beat_cnt[g*16 +: 16] = beat_cnt;
`endif
  end

endmodule

// File: tb/tb_cnn_layer_accel_axi_rd_resp_router.sv
// Bench for the read-response router: directed scenarios then random traffic,
// all checked against a queue-based model of the table and per-client buffers.
module tb_cnn_layer_accel_axi_rd_resp_router;

  localparam int NC    = 8;
  localparam int DW    = 64;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic           tag_reg_vld = 1'b0;
  logic [3:0]     tag_reg_id = '0;
  logic [2:0]     tag_reg_client = '0;
  logic [3:0]     axi_rid = '0;
  logic [DW-1:0]  axi_rdata = '0;
  logic [1:0]     axi_rresp = '0;
  logic           axi_rlast = 1'b0;
  logic           axi_rvalid = 1'b0;
  logic           axi_rready;
  logic [NC*DW-1:0] rd_data;
  logic [NC-1:0]  rd_vld;
  logic [NC-1:0]  rd_rdy = '0;
  logic [NC-1:0]  rd_cmpl;
  logic [NC-1:0]  resp_err;
  logic           tag_err;
`ifdef CNN_AXI_RD_RESP_BEAT_CNT_EN
  logic [NC*16-1:0] rd_beat_cnt;
  int               m_bcnt [NC];
`endif

  cnn_layer_accel_axi_rd_resp_router dut (
    .clk                   (clk),
    .rst                   (rst),
    .tag_reg_vld           (tag_reg_vld),
    .tag_reg_id            (tag_reg_id),
    .tag_reg_client        (tag_reg_client),
    .axi_rid               (axi_rid),
    .axi_rdata             (axi_rdata),
    .axi_rresp             (axi_rresp),
    .axi_rlast             (axi_rlast),
    .axi_rvalid            (axi_rvalid),
    .axi_rready            (axi_rready),
    .cX_init_read_data     (rd_data),
    .cX_init_read_data_vld (rd_vld),
    .cX_init_read_data_rdy (rd_rdy),
    .cX_init_read_cmpl     (rd_cmpl),
    .resp_err              (resp_err),
    .tag_err               (tag_err)
`ifdef CNN_AXI_RD_RESP_BEAT_CNT_EN
    ,
    .rd_beat_cnt           (rd_beat_cnt)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: ID table, per-client beat queues, sticky flags, pending cmpl.
  logic [DW:0]   q [NC][$];
  bit            m_vld [16];
  int            m_cli [16];
  bit [NC-1:0]   m_cmpl;
  bit [NC-1:0]   m_resp_err;
  bit            m_tag_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      q[k].delete();
`ifdef CNN_AXI_RD_RESP_BEAT_CNT_EN
      m_bcnt[k] = 0;
`endif
    end
    for (int i = 0; i < 16; i++) begin
      m_vld[i] = 1'b0;
      m_cli[i] = 0;
    end
    m_cmpl     = '0;
    m_resp_err = '0;
    m_tag_err  = 1'b0;
  endtask

  // One clock cycle: entered 1 ns after a rising edge with inputs already driven.
  task automatic step(output bit acc);
    bit          mapped;
    int          c;
    bit          exp_rdy;
    bit          treuse;
    bit [NC-1:0] pop;
    bit [NC-1:0] ncmpl;
    #3;
    mapped  = m_vld[axi_rid];
    c       = m_cli[axi_rid];
    exp_rdy = mapped ? (q[c].size() != DEPTH) : 1'b1;
    chk("rready", 64'(axi_rready), 64'(exp_rdy));
    for (int k = 0; k < NC; k++) begin
      chk("vld", 64'(rd_vld[k]), 64'(q[k].size() != 0));
      if (q[k].size() != 0)
        chk("data", rd_data[k*DW +: DW], q[k][0][DW-1:0]);
`ifdef CNN_AXI_RD_RESP_BEAT_CNT_EN
      chk("beat_cnt", 64'(rd_beat_cnt[k*16 +: 16]), 64'(m_bcnt[k]));
`endif
    end
    chk("cmpl", 64'(rd_cmpl), 64'(m_cmpl));
    chk("resp_err", 64'(resp_err), 64'(m_resp_err));
    chk("tag_err", 64'(tag_err), 64'(m_tag_err));

    acc = axi_rvalid && exp_rdy;
    for (int k = 0; k < NC; k++) begin
      pop[k]   = (q[k].size() != 0) && rd_rdy[k];
      ncmpl[k] = pop[k] && q[k][0][DW];
`ifdef CNN_AXI_RD_RESP_BEAT_CNT_EN
      if (m_cmpl[k]) m_bcnt[k] = 0;
      else if (pop[k] && m_bcnt[k] != 16'hFFFF) m_bcnt[k]++;
`endif
      if (pop[k]) void'(q[k].pop_front());
    end
    treuse = tag_reg_vld && m_vld[tag_reg_id];
    if (acc) begin
      if (mapped) begin
        q[c].push_back({axi_rlast, axi_rdata});
        if (axi_rresp != 2'b00) m_resp_err[c] = 1'b1;
        if (axi_rlast) m_vld[axi_rid] = 1'b0;
      end else begin
        m_tag_err = 1'b1;
      end
    end
    if (tag_reg_vld) begin
      if (treuse) m_tag_err = 1'b1;
      m_vld[tag_reg_id] = 1'b1;
      m_cli[tag_reg_id] = int'(tag_reg_client);
    end
    m_cmpl = ncmpl;
    @(posedge clk);
    #1;
  endtask

  task automatic reg_tag(input logic [3:0] id, input logic [2:0] cl);
    bit acc;
    tag_reg_vld = 1'b1;
    tag_reg_id = id;
    tag_reg_client = cl;
    step(acc);
    tag_reg_vld = 1'b0;
  endtask

  task automatic send_beat(input logic [3:0] id, input logic [63:0] d, input bit last,
                           input logic [1:0] resp);
    bit acc;
    int n;
    n = 0;
    axi_rvalid = 1'b1;
    axi_rid = id;
    axi_rdata = d;
    axi_rlast = last;
    axi_rresp = resp;
    do begin
      step(acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      n_chk++;
      n_err++;
      $display("FAIL beat_timeout: rid %0d not accepted within %0d cycles", id, n);
    end
    axi_rvalid = 1'b0;
    axi_rresp = 2'b00;
  endtask

  task automatic idle(input int n);
    bit acc;
    axi_rvalid = 1'b0;
    repeat (n) step(acc);
  endtask

  initial begin
    bit acc;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_vld", 64'(rd_vld), 64'd0);
    chk("rst_cmpl", 64'(rd_cmpl), 64'd0);
    chk("rst_rready", 64'(axi_rready), 64'd1);
    chk("rst_tag_err", 64'(tag_err), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single 4-beat burst to client 2.
    rd_rdy = 8'b0000_0100;
    reg_tag(4'd3, 3'd2);
    for (int i = 0; i < 4; i++) send_beat(4'd3, 64'hA0 + 64'(i), i == 3, 2'b00);
    idle(4);

    // Client 5 stalled: the FIFO fills after 8 beats, then drains when rdy returns.
    rd_rdy = 8'b0000_0000;
    reg_tag(4'd1, 3'd5);
    for (int i = 0; i < 8; i++) send_beat(4'd1, 64'h500 + 64'(i), 1'b0, 2'b00);
    axi_rvalid = 1'b1;
    axi_rid = 4'd1;
    axi_rdata = 64'h508;
    axi_rlast = 1'b0;
    #1;
    chk("full_rready", 64'(axi_rready), 64'd0);
    #1;
    step(acc);
    rd_rdy[5] = 1'b1;
    for (int i = 8; i < 12; i++) send_beat(4'd1, 64'h500 + 64'(i), i == 11, 2'b00);
    idle(14);

    // Two interleaved bursts to clients 0 and 1.
    rd_rdy = 8'b0000_0011;
    reg_tag(4'd1, 3'd0);
    reg_tag(4'd2, 3'd1);
    for (int i = 0; i < 4; i++) begin
      send_beat(4'd1, 64'h1000 + 64'(i), i == 3, 2'b00);
      send_beat(4'd2, 64'h2000 + 64'(i), i == 3, 2'b00);
    end
    idle(4);

    // Error response on the second beat still delivers all data.
    rd_rdy = 8'b0001_0000;
    reg_tag(4'd6, 3'd4);
    for (int i = 0; i < 3; i++)
      send_beat(4'd6, 64'h4400 + 64'(i), i == 2, (i == 1) ? 2'b10 : 2'b00);
    idle(4);

    // Released id 3 and never-registered id 7 are both drained and flagged.
    send_beat(4'd3, 64'hDEAD, 1'b1, 2'b00);
    send_beat(4'd7, 64'hBEEF, 1'b0, 2'b00);
    idle(2);

    // Reset with three beats buffered for client 3.
    rd_rdy = '0;
    reg_tag(4'd4, 3'd3);
    for (int i = 0; i < 3; i++) send_beat(4'd4, 64'h300 + 64'(i), 1'b0, 2'b00);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_vld", 64'(rd_vld), 64'd0);
    chk("midrst_cmpl", 64'(rd_cmpl), 64'd0);
    chk("midrst_tag_err", 64'(tag_err), 64'd0);
    chk("midrst_rready", 64'(axi_rready), 64'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rd_rdy = '1;
    idle(3);
    reg_tag(4'd4, 3'd3);
    for (int i = 0; i < 2; i++) send_beat(4'd4, 64'h3300 + 64'(i), i == 1, 2'b00);
    idle(4);

    // Random traffic.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      tag_reg_vld = ($urandom_range(0, 3) == 0);
      tag_reg_id = 4'($urandom_range(0, 15));
      tag_reg_client = 3'($urandom_range(0, NC - 1));
      axi_rvalid = ($urandom_range(0, 3) != 0);
      axi_rid = 4'($urandom_range(0, 15));
      for (int t = 0; t < 6 && !m_vld[axi_rid]; t++) axi_rid = 4'($urandom_range(0, 15));
      axi_rdata = {32'($urandom), 32'($urandom)};
      axi_rlast = ($urandom_range(0, 3) == 0);
      axi_rresp = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rd_rdy = NC'($urandom);
      step(acc);
    end
    tag_reg_vld = 1'b0;
    rd_rdy = '1;
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
